regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 118 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter feeding a register file through a one-entry output stage.
// Define WB_ARB_FWD_EN to forward the staged write onto the read ports.
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wb_hold,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         writereg,
  output logic [DATA_W-1:0]         writedata,
  input  logic [ADDR_W-1:0]         readreg1,
  input  logic [ADDR_W-1:0]         readreg2,
  input  logic [DATA_W-1:0]         rf_readdata1,
  input  logic [DATA_W-1:0]         rf_readdata2,
  output logic [DATA_W-1:0]         fwd_readdata1,
  output logic [DATA_W-1:0]         fwd_readdata2
);

  localparam int unsigned PtrW = (NUM_REQ > 2) ? 2 : 1;

  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic               stg_valid_q, stg_valid_d;
  logic [ADDR_W-1:0]  stg_addr_q, stg_addr_d;
  logic [DATA_W-1:0]  stg_data_q, stg_data_d;

  logic               gnt_found;
  logic [PtrW-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  // Two passes: first valid at or above ptr, otherwise the lowest valid below it.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_oh    = '0;
    sel_addr  = '0;
    sel_data  = '0;
    if (rst_n && !wb_hold) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!gnt_found && req_valid[i] && (PtrW'(i) >= ptr_q)) begin
          gnt_found = 1'b1;
          gnt_idx   = PtrW'(i);
        end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!gnt_found && req_valid[i]) begin
          gnt_found = 1'b1;
          gnt_idx   = PtrW'(i);
        end
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_found && (gnt_idx == PtrW'(i))) begin
        gnt_oh[i] = 1'b1;
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    stg_valid_d = stg_valid_q;
    stg_addr_d  = stg_addr_q;
    stg_data_d  = stg_data_q;
    if (!wb_hold) begin
      if (gnt_found) begin
        ptr_d       = (gnt_idx == PtrW'(NUM_REQ - 1)) ? '0 : gnt_idx + PtrW'(1);
        // Writes to r0 still handshake but never reach the register file.
        stg_valid_d = |sel_addr;
        stg_addr_d  = sel_addr;
        stg_data_d  = sel_data;
      end else begin
        stg_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      stg_valid_q <= 1'b0;
      stg_addr_q  <= '0;
      stg_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      stg_valid_q <= stg_valid_d;
      stg_addr_q  <= stg_addr_d;
      stg_data_q  <= stg_data_d;
    end
  end

  assign req_ready = gnt_oh;
  assign RegWrite  = stg_valid_q & ~wb_hold;
  assign writereg  = stg_addr_q;
  assign writedata = stg_data_q;

`ifdef WB_ARB_FWD_EN
  assign fwd_readdata1 = (stg_valid_q && (stg_addr_q == readreg1) && (readreg1 != '0)) ?
                         stg_data_q : rf_readdata1;
  assign fwd_readdata2 = (stg_valid_q && (stg_addr_q == readreg2) && (readreg2 != '0)) ?
                         stg_data_q : rf_readdata2;
`else
  logic unused_readreg;
  assign unused_readreg = ^{readreg1, readreg2};
  assign fwd_readdata1  = rf_readdata1;
  assign fwd_readdata2  = rf_readdata2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural arbiter model.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef WB_ARB_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            wb_hold = 1'b0;
  logic            RegWrite;
  logic [AW-1:0]   writereg;
  logic [DW-1:0]   writedata;
  logic [AW-1:0]   readreg1 = '0, readreg2 = '0;
  logic [DW-1:0]   rf_readdata1 = '0, rf_readdata2 = '0;
  logic [DW-1:0]   fwd_readdata1, fwd_readdata2;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .wb_hold(wb_hold), .RegWrite(RegWrite),
    .writereg(writereg), .writedata(writedata), .readreg1(readreg1), .readreg2(readreg2),
    .rf_readdata1(rf_readdata1), .rf_readdata2(rf_readdata2),
    .fwd_readdata1(fwd_readdata1), .fwd_readdata2(fwd_readdata2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input bit v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: pointer plus the pending register-file write, advanced once per cycle.
  int            m_ptr = 0;
  bit            m_v = 1'b0;
  logic [AW-1:0] m_a = '0;
  logic [DW-1:0] m_d = '0;

  initial begin
    int           g;
    logic [N-1:0] er;
    logic [DW-1:0] ef1, ef2;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ptr = 0; m_v = 1'b0; m_a = '0; m_d = '0;
        check("rst_ready", req_ready, '0);
        check("rst_regwrite", RegWrite, 1'b0);
      end else begin
        g = -1;
        if (!wb_hold)
          for (int k = 0; k < N; k++)
            if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("m_ready", req_ready, er);
        check("m_regwrite", RegWrite, m_v && !wb_hold);
        if (m_v && !wb_hold) begin
          check("m_writereg", writereg, m_a);
          check("m_writedata", writedata, m_d);
        end
      end
      ef1 = (FwdEn && m_v && m_a == readreg1 && readreg1 != 0) ? m_d : rf_readdata1;
      ef2 = (FwdEn && m_v && m_a == readreg2 && readreg2 != 0) ? m_d : rf_readdata2;
      check("m_fwd1", fwd_readdata1, ef1);
      check("m_fwd2", fwd_readdata2, ef2);
      if (rst_n && !wb_hold) begin
        if (g >= 0) begin
          m_a   = req_addr[g*AW +: AW];
          m_d   = req_data[g*DW +: DW];
          m_v   = (m_a != 0);
          m_ptr = (g + 1) % N;
        end else begin
          m_v = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [N-1:0] done;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Full contention: grants rotate 0,1,2 and writes trail by one cycle.
    set_req(0, 1, 5'd1, 32'hAAAA_0001);
    set_req(1, 1, 5'd2, 32'hBBBB_0002);
    set_req(2, 1, 5'd3, 32'hCCCC_0003);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rr_grant", req_ready, 3'b001 << (c % 3));
      if (c > 0) begin
        check("rr_regwrite", RegWrite, 1'b1);
        check("rr_writereg", writereg, (c - 1) % 3 + 1);
      end
      next_cycle();
    end
    req_valid = '0;
    @(negedge clk);
    check("rr_last_writereg", writereg, 5'd3);
    next_cycle();

    // Single requester 1: one write, one cycle later, then idle.
    set_req(1, 1, 5'd7, 32'hDEAD_BEEF);
    @(negedge clk);
    check("solo_grant", req_ready, 3'b010);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("solo_regwrite", RegWrite, 1'b1);
    check("solo_writereg", writereg, 5'd7);
    check("solo_writedata", writedata, 32'hDEAD_BEEF);
    next_cycle();
    @(negedge clk);
    check("solo_idle", RegWrite, 1'b0);
    next_cycle();

    // r0 write: handshake but no register-file write.
    set_req(0, 1, 5'd0, 32'h1234);
    @(negedge clk);
    check("r0_grant", req_ready, 3'b001);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("r0_regwrite", RegWrite, 1'b0);
    next_cycle();

    // Hold with a staged write and requester 2 waiting.
    set_req(1, 1, 5'd5, 32'h5555_5555);
    @(negedge clk);
    check("hold_setup_grant", req_ready, 3'b010);
    next_cycle();
    req_valid = '0;
    wb_hold = 1'b1;
    set_req(2, 1, 5'd6, 32'h6666_6666);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("hold_ready", req_ready, 3'b000);
      check("hold_regwrite", RegWrite, 1'b0);
      next_cycle();
    end
    wb_hold = 1'b0;
    @(negedge clk);
    check("unhold_regwrite", RegWrite, 1'b1);
    check("unhold_writereg", writereg, 5'd5);
    check("unhold_grant", req_ready, 3'b100);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("unhold_next_writereg", writereg, 5'd6);
    next_cycle();

    // Forwarding of the staged value, including while held.
    set_req(0, 1, 5'd9, 32'hCAFE_0000);
    next_cycle();
    req_valid = '0;
    wb_hold = 1'b1;
    readreg1 = 5'd9;
    rf_readdata1 = 32'h0;
    @(negedge clk);
    check("fwd_hit", fwd_readdata1, FwdEn ? 32'hCAFE_0000 : 32'h0);
    next_cycle();
    readreg1 = 5'd0;
    rf_readdata1 = 32'h1357;
    @(negedge clk);
    check("fwd_r0_pass", fwd_readdata1, 32'h1357);
    next_cycle();
    wb_hold = 1'b0;
    @(negedge clk);
    check("fwd_release_writereg", writereg, 5'd9);
    next_cycle();

    // Reset with a staged write and ptr=2.
    set_req(1, 1, 5'd4, 32'h4444_4444);
    next_cycle();
    req_valid = '0;
    check("prerst_regwrite", RegWrite, 1'b1);
    rst_n = 1'b0;
    set_req(0, 1, 5'd1, 32'h1);
    set_req(1, 1, 5'd2, 32'h2);
    set_req(2, 1, 5'd3, 32'h3);
    #1;
    check("rst_drop_regwrite", RegWrite, 1'b0);
    check("rst_no_ready", req_ready, 3'b000);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_grant", req_ready, 3'b001);
    check("postrst_no_replay", RegWrite, 1'b0);
    next_cycle();
    req_valid = '0;

    // Randomized traffic; requesters hold their payload until granted.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      done = req_valid & req_ready;
      next_cycle();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || done[i]) begin
          if ($urandom_range(0, 2) != 0)
            set_req(i, 1, 5'($urandom_range(0, 7)), $urandom);
          else
            req_valid[i] = 1'b0;
        end
      end
      wb_hold      = ($urandom_range(0, 4) == 0);
      readreg1     = 5'($urandom_range(0, 7));
      readreg2     = 5'($urandom_range(0, 7));
      rf_readdata1 = $urandom;
      rf_readdata2 = $urandom;
      rst_n        = ($urandom_range(0, 199) != 0);
    end
    rst_n = 1'b1;
    req_valid = '0;
    wb_hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
